// File: rtl/ascon_reg_pkg.sv
// rtl/ascon_reg_pkg.sv - register map, bus types and FSM encoding shared by the Ascon register initiator
package ascon_reg_pkg;

    localparam logic [31:0] ASCON_STATE_OFFS  = 32'h0000_0000;
    localparam logic [31:0] ASCON_CTRL_OFFS   = 32'h0000_0028;
    localparam logic [31:0] ASCON_STATUS_OFFS = 32'h0000_002C;
    localparam logic [31:0] ASCON_CTRL_START  = 32'h0000_0001;
    localparam int          ASCON_NUM_WORDS   = 10;

    typedef logic [4:0][63:0] ascon_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STATE,
        ST_WR_START,
        ST_WAIT,
        ST_RD_STATE,
        ST_RESP
    } ascon_init_state_e;

    // Word 2k carries state[k][31:0], word 2k+1 carries state[k][63:32]
    function automatic logic [31:0] ascon_word_offs(input logic [3:0] idx);
        return ASCON_STATE_OFFS + {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ascon_reg_xfer.sv
// rtl/ascon_reg_xfer.sv - single register transfer: drives one request and reports its completion
module ascon_reg_xfer
    import ascon_reg_pkg::*;
(
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output reg_req_t    reg_req,
    input  reg_rsp_t    reg_rsp,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata
);

    // Inputs come straight from the sequencer's registers, so the request
    // stays stable for as long as start is held waiting for ready.
    always_comb begin
        reg_req = '0;
        if (start) begin
            reg_req.valid = 1'b1;
            reg_req.addr  = addr;
            reg_req.write = write;
            reg_req.wdata = write ? wdata : 32'h0;
            reg_req.wstrb = 4'hF;
        end
    end

    assign done  = start && reg_rsp.ready;
    assign error = done && reg_rsp.error;
    assign rdata = reg_rsp.rdata;

endmodule

// File: rtl/ascon_reg_initiator.sv
// rtl/ascon_reg_initiator.sv - host-side sequencer that loads, starts and reads back the Ascon accelerator
// Optional: ASCON_REG_INITIATOR_INTR_WAIT_EN waits on intr_i instead of polling STATUS.
module ascon_reg_initiator
    import ascon_reg_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0,
    parameter int          PollMax  = 1024
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  ascon_state_t cmd_state_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output ascon_state_t rsp_state_o,
    output logic         rsp_error_o,
    output reg_req_t     reg_req_o,
    input  reg_rsp_t     reg_rsp_i,
    input  logic         intr_i,
    output logic         busy_o
);

    localparam int            PW        = $clog2(PollMax + 1);
    localparam logic [3:0]    LAST_WORD = 4'(ASCON_NUM_WORDS - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(PollMax - 1);

    ascon_init_state_e state_q, state_d;
    logic [3:0]        word_q, word_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic              err_q, err_d;
    logic [319:0]      cmd_q, cmd_d;
    logic [319:0]      res_q, res_d;
    logic              cmd_ready_q, rsp_valid_q;

    logic        xfer_start, xfer_write, xfer_done, xfer_error;
    logic [31:0] xfer_addr, xfer_wdata, xfer_rdata;

`ifdef ASCON_REG_INITIATOR_INTR_WAIT_EN
    logic intr_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) intr_q <= 1'b0;
        else          intr_q <= intr_i;
    end
`else
    logic unused_intr;
    assign unused_intr = intr_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            poll_q      <= '0;
            err_q       <= 1'b0;
            cmd_q       <= '0;
            res_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            poll_q      <= poll_d;
            err_q       <= err_d;
            cmd_q       <= cmd_d;
            res_q       <= res_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        poll_d     = poll_q;
        err_d      = err_q;
        cmd_d      = cmd_q;
        res_d      = res_q;
        xfer_start = 1'b0;
        xfer_write = 1'b0;
        xfer_addr  = '0;
        xfer_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_d   = cmd_state_i;
                    res_d   = '0;
                    word_d  = '0;
                    poll_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_WR_STATE;
                end
            end
            ST_WR_STATE: begin
                xfer_start = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = BaseAddr + ascon_word_offs(word_q);
                xfer_wdata = cmd_q[{word_q, 5'b0} +: 32];
                if (xfer_error) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (xfer_done) begin
                    word_d  = (word_q == LAST_WORD) ? 4'd0 : word_q + 4'd1;
                    state_d = (word_q == LAST_WORD) ? ST_WR_START : ST_WR_STATE;
                end
            end
            ST_WR_START: begin
                xfer_start = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = BaseAddr + ASCON_CTRL_OFFS;
                xfer_wdata = ASCON_CTRL_START;
                if (xfer_error) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (xfer_done) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
`ifdef ASCON_REG_INITIATOR_INTR_WAIT_EN
                if (intr_q) begin
                    word_d  = '0;
                    state_d = ST_RD_STATE;
                end else if (poll_q == POLL_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    poll_d = poll_q + 1'b1;
                end
`else
                xfer_start = 1'b1;
                xfer_addr  = BaseAddr + ASCON_STATUS_OFFS;
                if (xfer_error) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (xfer_done) begin
                    if (xfer_rdata[0]) begin
                        word_d  = '0;
                        state_d = ST_RD_STATE;
                    end else if (poll_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        poll_d = poll_q + 1'b1;
                    end
                end
`endif
            end
            ST_RD_STATE: begin
                xfer_start = 1'b1;
                xfer_addr  = BaseAddr + ascon_word_offs(word_q);
                // A failed read leaves its word at zero; earlier words are kept
                if (xfer_error) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (xfer_done) begin
                    res_d[{word_q, 5'b0} +: 32] = xfer_rdata;
                    word_d  = (word_q == LAST_WORD) ? 4'd0 : word_q + 4'd1;
                    state_d = (word_q == LAST_WORD) ? ST_RESP : ST_RD_STATE;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ascon_reg_xfer u_xfer (
        .start   (xfer_start),
        .addr    (xfer_addr),
        .write   (xfer_write),
        .wdata   (xfer_wdata),
        .reg_req (reg_req_o),
        .reg_rsp (reg_rsp_i),
        .done    (xfer_done),
        .error   (xfer_error),
        .rdata   (xfer_rdata)
    );

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_state_o = res_q;
    assign rsp_error_o = err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ascon_reg_initiator.sv
// tb/tb_ascon_reg_initiator.sv - self-checking bench for ascon_reg_initiator with a register slave model
module tb_ascon_reg_initiator;
    import ascon_reg_pkg::*;

    typedef struct {
        int          waits;
        int          finish_at;
        logic [31:0] err_addr;
        bit          err_rd;
        bit          rand_perm;
        bit          exp_err;
        int          exp_polls;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xfer_t;

    localparam logic [31:0] NONE  = 32'hFFFF_FFFF;
    localparam logic [31:0] BASE2 = 32'h4000_0000;
    localparam int          LIM   = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_error, busy, intr;
    ascon_state_t cmd_state, rsp_state;
    reg_req_t     req;
    reg_rsp_t     rsp;
    logic         cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, rsp_error2, busy2;
    ascon_state_t cmd_state2, rsp_state2;
    reg_req_t     req2;
    reg_rsp_t     rsp2;

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        tab [8];
    vec_t        cur;
    logic [31:0] perm [10];
    xfer_t       log_q [$];
    int          status_reads = 0;
    int          status_base  = 0;
    int          hold_errs    = 0;
    int          ws_cnt       = 0;
    reg_req_t    held;
    bit          hold_valid   = 1'b0;
    int          st2 = 0;
    int          rd2 = 0;

    ascon_reg_initiator dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_state_i(cmd_state),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_state_o(rsp_state),
        .rsp_error_o(rsp_error), .reg_req_o(req), .reg_rsp_i(rsp),
        .intr_i(intr), .busy_o(busy)
    );

    ascon_reg_initiator #(.BaseAddr(BASE2), .PollMax(4)) dut_to (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_state_i(cmd_state2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_state_o(rsp_state2),
        .rsp_error_o(rsp_error2), .reg_req_o(req2), .reg_rsp_i(rsp2),
        .intr_i(intr), .busy_o(busy2)
    );

    // Slave for the main instance: wait states, FINISHED after N polls, one injected error
    always_comb begin
        rsp       = '0;
        rsp.ready = req.valid && (ws_cnt == cur.waits);
        if (req.addr == ASCON_STATUS_OFFS)
            rsp.rdata = (status_reads - status_base + 1 >= cur.finish_at) ? 32'h1 : 32'h0;
        else if (req.addr < ASCON_CTRL_OFFS)
            rsp.rdata = perm[req.addr[5:2]];
        rsp.error = rsp.ready && (req.addr == cur.err_addr) && (req.write == !cur.err_rd);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            ws_cnt     <= 0;
            hold_valid <= 1'b0;
        end else if (req.valid) begin
            if (hold_valid && req != held) hold_errs <= hold_errs + 1;
            if (rsp.ready) begin
                log_q.push_back('{write: req.write, addr: req.addr, wdata: req.wdata, wstrb: req.wstrb});
                if (!req.write && req.addr == ASCON_STATUS_OFFS) status_reads <= status_reads + 1;
                ws_cnt     <= 0;
                hold_valid <= 1'b0;
            end else begin
                ws_cnt     <= ws_cnt + 1;
                held       <= req;
                hold_valid <= 1'b1;
            end
        end
    end

    // Slave for the timeout instance: zero-wait, FINISHED never set
    always_comb begin
        rsp2       = '0;
        rsp2.ready = req2.valid;
    end

    always @(posedge clk) begin
        if (rst_n && req2.valid && !req2.write) begin
            if (req2.addr == BASE2 + ASCON_STATUS_OFFS) st2 <= st2 + 1;
            else if (req2.addr < BASE2 + ASCON_CTRL_OFFS) rd2 <= rd2 + 1;
        end
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit hit(input vec_t v, input logic wr, input logic [31:0] a);
        return (a == v.err_addr) && (wr == !v.err_rd);
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [319:0] cmd_flat, exp_res, snap;
        xfer_t        eq [$];
        xfer_t        a;
        bit           stop, stable, serr;
        int           lat, base, sbase, hb, hold;
        string        tag;
        tag = $sformatf("v%0d", idx);
        cur = v;
        for (int w = 0; w < 10; w++) perm[w] = v.rand_perm ? $urandom : 32'(w + 1);
        for (int w = 0; w < 10; w++) cmd_flat[32*w +: 32] = $urandom;

        // Reference: the transfer list and result implied by the register protocol
        exp_res = '0;
        stop    = 1'b0;
        for (int w = 0; w < 10 && !stop; w++) begin
            eq.push_back('{write: 1'b1, addr: 32'(4*w), wdata: cmd_flat[32*w +: 32], wstrb: 4'hF});
            stop = hit(v, 1'b1, 32'(4*w));
        end
        if (!stop) begin
            eq.push_back('{write: 1'b1, addr: 32'h28, wdata: 32'h1, wstrb: 4'hF});
            stop = hit(v, 1'b1, 32'h28);
        end
        for (int p = 1; !stop; p++) begin
            eq.push_back('{write: 1'b0, addr: 32'h2C, wdata: 32'h0, wstrb: 4'hF});
            stop = hit(v, 1'b0, 32'h2C);
            if (p >= v.finish_at) break;
        end
        for (int w = 0; w < 10 && !stop; w++) begin
            eq.push_back('{write: 1'b0, addr: 32'(4*w), wdata: 32'h0, wstrb: 4'hF});
            stop = hit(v, 1'b0, 32'(4*w));
            if (!stop) exp_res[32*w +: 32] = perm[w];
        end

        base        = log_q.size();
        sbase       = status_reads;
        status_base = sbase;
        hb          = hold_errs;
        @(negedge clk);
        check({tag, "_idle_ready"}, cmd_ready, 1'b1);
        cmd_state = cmd_flat;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp_seen"}, lat < LIM, 1'b1);
        if (lat >= LIM) begin
            rst_n = 1'b0;
            @(negedge clk) rst_n = 1'b1;
            return;
        end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_error"}, rsp_error, v.exp_err);
        check({tag, "_state"}, rsp_state, exp_res);
        check({tag, "_polls"}, status_reads - sbase, v.exp_polls);
        check({tag, "_req_hold"}, hold_errs - hb, 0);

        hold   = (idx == 0) ? 10 : int'($urandom_range(1, 3));
        snap   = rsp_state;
        serr   = rsp_error;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_state !== snap || rsp_error !== serr || cmd_ready || !busy) stable = 1'b0;
        end
        check({tag, "_bp_stable"}, stable, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, rsp_valid, 1'b0);
        check({tag, "_busy_drop"}, busy, 1'b0);

        check({tag, "_log_len"}, log_q.size() - base, eq.size());
        for (int k = 0; k < eq.size() && base + k < log_q.size(); k++) begin
            a = log_q[base + k];
            check($sformatf("%s_x%0d_write", tag, k), a.write, eq[k].write);
            check($sformatf("%s_x%0d_addr", tag, k), a.addr, eq[k].addr);
            check($sformatf("%s_x%0d_wstrb", tag, k), a.wstrb, eq[k].wstrb);
            if (eq[k].write) check($sformatf("%s_x%0d_wdata", tag, k), a.wdata, eq[k].wdata);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_error"}, rsp_error, 1'b0);
        check({tag, "_rsp_state"}, rsp_state, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_reg_req"}, req, '0);
    endtask

    initial begin
        //         waits fin err_addr err_rd rand  err  polls lat
        tab[0] = '{0, 1, NONE,  1'b0, 1'b0, 1'b0, 1, 23};
        tab[1] = '{3, 1, NONE,  1'b0, 1'b1, 1'b0, 1, 89};
        tab[2] = '{0, 5, NONE,  1'b0, 1'b1, 1'b0, 5, 27};
        tab[3] = '{0, 1, 32'hC, 1'b0, 1'b1, 1'b1, 0, 5};
        tab[4] = '{1, 2, NONE,  1'b0, 1'b1, 1'b0, 2, 47};
        tab[5] = '{0, 1, 32'h28, 1'b0, 1'b1, 1'b1, 0, 12};
        tab[6] = '{0, 1, 32'h2C, 1'b1, 1'b1, 1'b1, 1, 13};
        tab[7] = '{2, 1, 32'h10, 1'b1, 1'b1, 1'b1, 1, 52};

        rst_n      = 1'b0;
        intr       = 1'b0;
        cmd_valid  = 1'b0;
        rsp_ready  = 1'b0;
        cmd_state  = '0;
        cmd_valid2 = 1'b0;
        rsp_ready2 = 1'b0;
        cmd_state2 = '0;
        cur        = tab[0];
        for (int w = 0; w < 10; w++) perm[w] = 32'(w + 1);

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("por_release_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_vec(tab[i], i);

        // Reset during readback must drop every output at once
        begin
            int n;
            cur = tab[0];
            for (int w = 0; w < 10; w++) perm[w] = 32'(w + 1);
            status_base = status_reads;
            @(negedge clk);
            cmd_state = {10{32'hA5A5_0000}};
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            n = 0;
            while (!(req.valid && !req.write && req.addr < ASCON_CTRL_OFFS) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rst_reach_rd", n < 200, 1'b1);
            @(negedge clk);
            @(negedge clk);
            check("rst_partial_nonzero", rsp_state != '0, 1'b1);
            rst_n = 1'b0;
            #1 check_reset_outputs("midrst");
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk);
            #1 check("midrst_release_ready", cmd_ready, 1'b1);
        end

        run_vec(tab[0], 8);

        // Poll timeout on the PollMax=4 instance at a non-zero base address
        begin
            int lat, s0, r0;
            s0 = st2;
            r0 = rd2;
            @(negedge clk);
            check("to_idle_ready", cmd_ready2, 1'b1);
            cmd_state2 = {$urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom, $urandom};
            cmd_valid2 = 1'b1;
            @(posedge clk);
            #1 cmd_valid2 = 1'b0;
            lat = 0;
            while (!rsp_valid2 && lat < LIM) begin
                @(negedge clk);
                lat++;
            end
            check("to_rsp_seen", lat < LIM, 1'b1);
            check("to_latency", lat, 16);
            check("to_error", rsp_error2, 1'b1);
            check("to_status_reads", st2 - s0, 4);
            check("to_state_reads", rd2 - r0, 0);
            check("to_state", rsp_state2, '0);
            rsp_ready2 = 1'b1;
            @(posedge clk);
            #1 rsp_ready2 = 1'b0;
            check("to_busy_drop", busy2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
